// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART.
// Frame = start(0), DATABITS LSB-first, optional parity, STOPBITS stop bits (1).
// TX and RX run from the same bit period DIV = SCYCLE/BAUDRATE but are independent.
module uart_param #(
  parameter int SCYCLE   = 50_000_000,
  parameter int BAUDRATE = 115200,
  parameter int DATABITS = 8,
  parameter int PARITY   = 0,   // 0 none, 1 odd, 2 even
  parameter int STOPBITS = 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic                tx,
  input  logic [DATABITS-1:0] txdata,
  input  logic                txstart,
  output logic                txbusy,
  output logic                txdone,
  input  logic                rx,
  output logic [DATABITS-1:0] rxdata,
  output logic                rxbusy,
  output logic                rxdone,
  output logic                rxperr,
  output logic                rxferr
);

  localparam int DIV = SCYCLE / BAUDRATE;
  localparam int CW  = $clog2(DIV);

  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(DIV / 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATABITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOPBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- TX path
  state_t                tx_state, tx_state_n;
  logic [CW-1:0]         tx_cnt, tx_cnt_n;
  logic [3:0]            tx_bit, tx_bit_n;
  logic [DATABITS-1:0]   tx_shift, tx_shift_n;
  logic                  tx_par, tx_par_n;
  logic                  tx_n;
  logic                  txdone_n;

  // TX state and line registers; the line idles high so it resets to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      txdone   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values, independent of statement order.
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx       <= tx_n;
      txdone   <= txdone_n;
    end
  end

  // TX next state: each bit lasts DIV cycles, the line value is registered.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_n       = tx;
    txdone_n   = 1'b0;
    if (tx_state == S_IDLE) begin
      tx_n = 1'b1;
      if (txstart) begin
        tx_shift_n = txdata;
        tx_par_n   = (PARITY == 1) ? ~^txdata : ^txdata;
        tx_cnt_n   = BIT_LAST;
        tx_state_n = S_START;
        tx_n       = 1'b0;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt_n = tx_cnt - CW'(1);
    end else begin
      tx_cnt_n = BIT_LAST;
      case (tx_state)
        S_START: begin
          tx_state_n = S_DATA;
          tx_bit_n   = '0;
          tx_n       = tx_shift[0];
        end
        S_DATA: begin
          if (tx_bit == DATA_LAST) begin
            tx_bit_n = '0;
            if (PARITY != 0) begin
              tx_state_n = S_PARITY;
              tx_n       = tx_par;
            end else begin
              tx_state_n = S_STOP;
              tx_n       = 1'b1;
            end
          end else begin
            tx_bit_n   = tx_bit + 4'd1;
            tx_shift_n = tx_shift >> 1;
            tx_n       = tx_shift[1];
          end
        end
        S_PARITY: begin
          tx_state_n = S_STOP;
          tx_bit_n   = '0;
          tx_n       = 1'b1;
        end
        S_STOP: begin
          tx_n = 1'b1;
          if (tx_bit == STOP_LAST) begin
            // Back in IDLE while TXDONE is high, so a new start is accepted here.
            tx_state_n = S_IDLE;
            txdone_n   = 1'b1;
          end else begin
            tx_bit_n = tx_bit + 4'd1;
          end
        end
        default: tx_state_n = S_IDLE;
      endcase
    end
  end

  assign txbusy = (tx_state != S_IDLE);

  // ---------------------------------------------------------------- RX path
  logic                  rx_s1, rx_s2, rx_q;
  state_t                rx_state, rx_state_n;
  logic [CW-1:0]         rx_cnt, rx_cnt_n;
  logic [3:0]            rx_bit, rx_bit_n;
  logic [DATABITS-1:0]   rx_shift, rx_shift_n;
  logic                  rx_pbit, rx_pbit_n;
  logic [DATABITS-1:0]   rxdata_n;
  logic                  rxdone_n, rxperr_n, rxferr_n;
  logic                  rx_fall;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  assign rx_fall = rx_q & ~rx_s2;

  // RX state and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_pbit  <= 1'b0;
      rxdata   <= '0;
      rxdone   <= 1'b0;
      rxperr   <= 1'b0;
      rxferr   <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_pbit  <= rx_pbit_n;
      rxdata   <= rxdata_n;
      rxdone   <= rxdone_n;
      rxperr   <= rxperr_n;
      rxferr   <= rxferr_n;
    end
  end

  // RX next state: validate the start bit at half-bit, then sample bit centres.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_pbit_n  = rx_pbit;
    rxdata_n   = rxdata;
    rxdone_n   = 1'b0;
    rxperr_n   = rxperr;
    rxferr_n   = rxferr;
    if (rx_state == S_IDLE) begin
      if (rx_fall) begin
        rx_state_n = S_START;
        rx_cnt_n   = HALF_BIT;
      end
    end else if (rx_cnt != '0) begin
      rx_cnt_n = rx_cnt - CW'(1);
    end else begin
      rx_cnt_n = BIT_LAST;
      case (rx_state)
        S_START: begin
          // A line back high at half-bit was a glitch; drop it silently.
          rx_state_n = rx_s2 ? S_IDLE : S_DATA;
          rx_bit_n   = '0;
        end
        S_DATA: begin
          rx_shift_n = {rx_s2, rx_shift[DATABITS-1:1]};
          if (rx_bit == DATA_LAST) begin
            rx_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            rx_bit_n = rx_bit + 4'd1;
          end
        end
        S_PARITY: begin
          rx_pbit_n  = rx_s2;
          rx_state_n = S_STOP;
        end
        S_STOP: begin
          // Only the first stop bit is checked; re-arm straight away.
          rx_state_n = S_IDLE;
          rxdone_n   = 1'b1;
          rxdata_n   = rx_shift;
          rxferr_n   = ~rx_s2;
          if (PARITY == 0)      rxperr_n = 1'b0;
          else if (PARITY == 1) rxperr_n = ~(^rx_shift ^ rx_pbit);
          else                  rxperr_n = ^rx_shift ^ rx_pbit;
        end
        default: rx_state_n = S_IDLE;
      endcase
    end
  end

  assign rxbusy = (rx_state != S_IDLE);

endmodule
